// File: rtl/cr_osf_dbg_fifo_ctl_mc.sv
// Multi-channel debug-FIFO controller: per channel, moves source entries into a debug FIFO
// and drains it to the outbound FIFO in pass, capture, single-step or burst-step mode.
module cr_osf_dbg_fifo_ctl_mc #(
    parameter int NUM_CH      = 2,
    parameter int DEPTH       = 64,
    parameter int FULL_MARGIN = 2,
    parameter int CRED_W      = 8,
    parameter int DW          = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2*NUM_CH-1:0]        cfg_mode,
    input  logic [CRED_W*NUM_CH-1:0]   cfg_burst_len,
    input  logic [NUM_CH-1:0]          step_pulse,
    input  logic [NUM_CH-1:0]          src_empty,
    input  logic [NUM_CH-1:0]          src_aempty,
    output logic [NUM_CH-1:0]          src_rd,
    input  logic [DW*NUM_CH-1:0]       fifo_depth,
    output logic [NUM_CH-1:0]          fifo_wr,
    output logic [NUM_CH-1:0]          fifo_rd,
    input  logic [NUM_CH-1:0]          ob_afull,
    output logic [NUM_CH-1:0]          ob_wr,
    output logic [2*NUM_CH-1:0]        ch_state,
    output logic [NUM_CH-1:0]          step_done
);

    typedef enum logic [1:0] {
        ST_PASS = 2'b00,
        ST_HOLD = 2'b01,
        ST_STEP = 2'b10
    } state_e;

    localparam logic [1:0]    M_PASS   = 2'b00;
    localparam logic [1:0]    M_CAPT   = 2'b01;
    localparam logic [1:0]    M_STEP   = 2'b10;
    localparam logic [1:0]    M_BURST  = 2'b11;
    localparam int            CW1      = CRED_W + 1;
    localparam logic [DW-1:0] FULL_LVL = DW'(DEPTH - FULL_MARGIN);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [1:0]        mode;
            logic [CRED_W-1:0] burst_len;
            logic [DW-1:0]     depth;

            logic              fifo_wr_reg;
            logic              fifo_rd_reg;
            logic              ob_wr_reg;
            logic              step_done_reg;
            logic [CRED_W-1:0] credit_reg;
            logic [1:0]        mode_prev_reg;
            state_e            state_reg;

            logic              full;
            logic [DW-1:0]     eff_depth;
            logic              empty_mod;
            logic              allow;
            logic              wr_next;
            logic              rd_next;
            logic [CW1-1:0]    cred_sum;
            logic [CRED_W-1:0] credit_next;
            logic              drain_zero;
            state_e            state_next;

            assign mode      = cfg_mode[2*gi +: 2];
            assign burst_len = cfg_burst_len[CRED_W*gi +: CRED_W];
            assign depth     = fifo_depth[DW*gi +: DW];

            always_comb begin
                full      = (depth >= FULL_LVL);
                // Depth lags by a cycle, so discount the pop already in flight.
                eff_depth = depth - DW'(fifo_rd_reg);
                empty_mod = (eff_depth == '0);
                wr_next   = !src_empty[gi] && !(fifo_wr_reg && src_aempty[gi]) && !full;

                case (mode)
                    M_PASS:  allow = 1'b1;
                    M_CAPT:  allow = 1'b0;
                    default: allow = (credit_reg != '0);
                endcase
                rd_next = !empty_mod && !ob_afull[gi] && allow;

                cred_sum    = {1'b0, credit_reg} + CW1'(step_pulse[gi]) - CW1'(rd_next);
                credit_next = credit_reg;
                drain_zero  = 1'b0;
                if (mode == M_PASS || mode == M_CAPT || mode != mode_prev_reg) begin
                    credit_next = '0;
                end else if (mode == M_BURST && step_pulse[gi]) begin
                    credit_next = burst_len;
                end else if (mode == M_STEP) begin
                    credit_next = cred_sum[CRED_W] ? '1 : cred_sum[CRED_W-1:0];
                    drain_zero  = rd_next && !step_pulse[gi] && (credit_reg == CRED_W'(1));
                end else begin
                    credit_next = credit_reg - CRED_W'(rd_next);
                    drain_zero  = rd_next && (credit_reg == CRED_W'(1));
                end

                if (mode == M_PASS) begin
                    state_next = ST_PASS;
                end else if (credit_next == '0) begin
                    state_next = ST_HOLD;
                end else begin
                    state_next = ST_STEP;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    fifo_wr_reg   <= 1'b0;
                    fifo_rd_reg   <= 1'b0;
                    ob_wr_reg     <= 1'b0;
                    step_done_reg <= 1'b0;
                    credit_reg    <= '0;
                    mode_prev_reg <= M_PASS;
                    state_reg     <= ST_PASS;
                end else begin
                    fifo_wr_reg   <= wr_next;
                    fifo_rd_reg   <= rd_next;
                    ob_wr_reg     <= fifo_rd_reg;
                    step_done_reg <= drain_zero;
                    credit_reg    <= credit_next;
                    mode_prev_reg <= mode;
                    state_reg     <= state_next;
                end
            end

            assign fifo_wr[gi]         = fifo_wr_reg;
            assign src_rd[gi]          = fifo_wr_reg;
            assign fifo_rd[gi]         = fifo_rd_reg;
            assign ob_wr[gi]           = ob_wr_reg;
            assign step_done[gi]       = step_done_reg;
            assign ch_state[2*gi +: 2] = state_reg;
        end
    endgenerate

endmodule

// File: tb/tb_cr_osf_dbg_fifo_ctl_mc.sv
// Bench for cr_osf_dbg_fifo_ctl_mc: source/debug FIFO occupancy models around the DUT,
// a table of per-channel scenarios plus hand-written multi-cycle corner cases.
module tb_cr_osf_dbg_fifo_ctl_mc;
    localparam int NUM_CH      = 2;
    localparam int DEPTH       = 64;
    localparam int FULL_MARGIN = 2;
    localparam int CRED_W      = 8;
    localparam int DW          = $clog2(DEPTH + 1);

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [2*NUM_CH-1:0]      cfg_mode = '0;
    logic [CRED_W*NUM_CH-1:0] cfg_burst_len = '0;
    logic [NUM_CH-1:0]        step_pulse = '0;
    logic [NUM_CH-1:0]        src_empty = '1;
    logic [NUM_CH-1:0]        src_aempty = '1;
    logic [NUM_CH-1:0]        src_rd;
    logic [DW*NUM_CH-1:0]     fifo_depth = '0;
    logic [NUM_CH-1:0]        fifo_wr;
    logic [NUM_CH-1:0]        fifo_rd;
    logic [NUM_CH-1:0]        ob_afull = '0;
    logic [NUM_CH-1:0]        ob_wr;
    logic [2*NUM_CH-1:0]      ch_state;
    logic [NUM_CH-1:0]        step_done;

    cr_osf_dbg_fifo_ctl_mc #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .FULL_MARGIN(FULL_MARGIN), .CRED_W(CRED_W), .DW(DW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_burst_len(cfg_burst_len),
        .step_pulse(step_pulse), .src_empty(src_empty), .src_aempty(src_aempty),
        .src_rd(src_rd), .fifo_depth(fifo_depth), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
        .ob_afull(ob_afull), .ob_wr(ob_wr), .ch_state(ch_state), .step_done(step_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int         src;
        int         pre;
        int         blen;
        int         pulses;
        int         e_wr;
        int         e_rd;
        int         e_ob;
        int         e_done;
        int         e_depth;
        logic [1:0] e_state;
    } vec_t;

    vec_t tbl [4][NUM_CH];

    int src_cnt [NUM_CH];
    int dbg     [NUM_CH];
    int n_wr    [NUM_CH];
    int n_rd    [NUM_CH];
    int n_ob    [NUM_CH];
    int n_done  [NUM_CH];
    int viol    [NUM_CH];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_env();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            src_empty[ch]            = (src_cnt[ch] == 0);
            src_aempty[ch]           = (src_cnt[ch] <= 1);
            fifo_depth[DW*ch +: DW]  = DW'(dbg[ch]);
        end
    endtask

    // One clock: apply last cycle's push/pop to the FIFO models, then sample outputs at edge+1.
    task automatic tick();
        logic [NUM_CH-1:0] w;
        logic [NUM_CH-1:0] r;
        w = fifo_wr;
        r = fifo_rd;
        @(posedge clk);
        #1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (w[ch]) begin
                if (src_cnt[ch] == 0) viol[ch]++;
                else src_cnt[ch]--;
                dbg[ch]++;
            end
            if (r[ch]) begin
                if (dbg[ch] == 0) viol[ch]++;
                else dbg[ch]--;
            end
            if (ob_wr[ch] != r[ch]) viol[ch]++;
            if (src_rd[ch] != fifo_wr[ch]) viol[ch]++;
            n_wr[ch]   += int'(fifo_wr[ch]);
            n_rd[ch]   += int'(fifo_rd[ch]);
            n_ob[ch]   += int'(ob_wr[ch]);
            n_done[ch] += int'(step_done[ch]);
        end
        drive_env();
    endtask

    task automatic set_cfg(input int ch, input logic [1:0] mode, input int blen);
        cfg_mode[2*ch +: 2]                = mode;
        cfg_burst_len[CRED_W*ch +: CRED_W] = CRED_W'(blen);
    endtask

    task automatic clear_counts();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            n_wr[ch] = 0; n_rd[ch] = 0; n_ob[ch] = 0; n_done[ch] = 0; viol[ch] = 0;
        end
    endtask

    task automatic start(input int s0, input int p0, input int s1, input int p1);
        rst        = 1'b1;
        step_pulse = '0;
        ob_afull   = '0;
        repeat (2) @(posedge clk);
        #1;
        src_cnt[0] = s0; dbg[0] = p0;
        src_cnt[1] = s1; dbg[1] = p1;
        clear_counts();
        drive_env();
        rst = 1'b0;
    endtask

    initial begin
        int afull_bp;
        int bp_viol;

        //                 mode   src pre blen pls  wr  rd  ob done dep state
        tbl[0][0] = '{2'b00,  10,  0,  0,  0,  10, 10, 10, 0,   0, 2'b00};
        tbl[0][1] = '{2'b01, 100,  0,  0,  0,  63,  0,  0, 0,  63, 2'b01};
        tbl[1][0] = '{2'b10,   0,  5,  0,  3,   0,  3,  3, 3,   2, 2'b01};
        tbl[1][1] = '{2'b11,   0, 20,  4,  1,   0,  4,  4, 1,  16, 2'b01};
        tbl[2][0] = '{2'b11,   0,  3,  0,  2,   0,  0,  0, 0,   3, 2'b01};
        tbl[2][1] = '{2'b10,   3,  0,  0,  5,   3,  3,  3, 3,   0, 2'b10};
        tbl[3][0] = '{2'b00,   0,  7,  0,  0,   0,  7,  7, 0,   0, 2'b00};
        tbl[3][1] = '{2'b01,   1,  0,  0,  0,   1,  0,  0, 0,   1, 2'b01};

        // Reset state
        start(0, 0, 0, 0);
        check("rst fifo_wr", int'(fifo_wr), 0);
        check("rst fifo_rd", int'(fifo_rd), 0);
        check("rst ob_wr", int'(ob_wr), 0);
        check("rst step_done", int'(step_done), 0);
        check("rst ch_state", int'(ch_state), 0);

        // Table-driven scenarios, both channels concurrently; pulses at cycles 5, 15, 25, ...
        for (int row = 0; row < 4; row++) begin
            for (int ch = 0; ch < NUM_CH; ch++) set_cfg(ch, tbl[row][ch].mode, tbl[row][ch].blen);
            start(tbl[row][0].src, tbl[row][0].pre, tbl[row][1].src, tbl[row][1].pre);
            for (int c = 0; c < 130; c++) begin
                for (int ch = 0; ch < NUM_CH; ch++)
                    step_pulse[ch] = (c >= 5) && ((c - 5) % 10 == 0) && ((c - 5) / 10 < tbl[row][ch].pulses);
                tick();
            end
            step_pulse = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                check($sformatf("r%0d ch%0d fifo_wr count", row, ch), n_wr[ch], tbl[row][ch].e_wr);
                check($sformatf("r%0d ch%0d fifo_rd count", row, ch), n_rd[ch], tbl[row][ch].e_rd);
                check($sformatf("r%0d ch%0d ob_wr count", row, ch), n_ob[ch], tbl[row][ch].e_ob);
                check($sformatf("r%0d ch%0d step_done count", row, ch), n_done[ch], tbl[row][ch].e_done);
                check($sformatf("r%0d ch%0d final depth", row, ch), dbg[ch], tbl[row][ch].e_depth);
                check($sformatf("r%0d ch%0d ch_state", row, ch), int'(ch_state[2*ch +: 2]), int'(tbl[row][ch].e_state));
                check($sformatf("r%0d ch%0d protocol violations", row, ch), viol[ch], 0);
            end
        end

        // Burst reload: pulse at 3 loads 4, second pulse at 5 reloads 4 -> 2 + 4 reads
        set_cfg(0, 2'b11, 4);
        set_cfg(1, 2'b01, 0);
        start(0, 20, 0, 0);
        for (int c = 0; c < 30; c++) begin
            step_pulse[0] = (c == 3) || (c == 5);
            tick();
            if (c == 3) check("reload ch_state after pulse", int'(ch_state[1:0]), 2);
        end
        step_pulse = '0;
        check("reload fifo_rd count", n_rd[0], 6);
        check("reload step_done count", n_done[0], 1);
        check("reload final depth", dbg[0], 14);
        check("reload ch_state", int'(ch_state[1:0]), 1);
        check("reload violations", viol[0], 0);

        // Mode change mid-burst: credit cleared, no step_done
        set_cfg(0, 2'b11, 8);
        start(0, 20, 0, 0);
        for (int c = 0; c < 20; c++) begin
            step_pulse[0] = (c == 3);
            if (c == 6) set_cfg(0, 2'b01, 8);
            tick();
        end
        step_pulse = '0;
        check("modechg fifo_rd count", n_rd[0], 2);
        check("modechg step_done count", n_done[0], 0);
        check("modechg final depth", dbg[0], 18);
        check("modechg ch_state", int'(ch_state[1:0]), 1);

        // Backpressure: ob_afull high in cycles where (c/3) is odd
        set_cfg(0, 2'b00, 0);
        start(0, 30, 0, 0);
        bp_viol = 0;
        for (int c = 0; c < 33; c++) begin
            afull_bp    = (c >= 30) ? 1 : ((c / 3) % 2);
            ob_afull[0] = afull_bp[0];
            tick();
            if (fifo_rd[0] && afull_bp == 1) bp_viol++;
        end
        ob_afull = '0;
        check("bp read under afull", bp_viol, 0);
        check("bp fifo_rd count", n_rd[0], 15);
        check("bp ob_wr count", n_ob[0], 15);
        check("bp final depth", dbg[0], 15);
        check("bp violations", viol[0], 0);

        // Asynchronous reset mid-burst with credit 3 and a pop in flight
        set_cfg(0, 2'b11, 6);
        start(0, 20, 0, 0);
        for (int c = 0; c < 6; c++) begin
            step_pulse[0] = (c == 2);
            tick();
        end
        step_pulse = '0;
        check("pre-reset fifo_rd", int'(fifo_rd[0]), 1);
        check("pre-reset ch_state", int'(ch_state[1:0]), 2);
        #2 rst = 1'b1;
        #1;
        check("async rst outputs", int'({fifo_wr, fifo_rd, ob_wr, step_done, ch_state}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_counts();
        for (int c = 0; c < 10; c++) tick();
        check("post-reset fifo_rd count", n_rd[0], 0);
        check("post-reset ob_wr count", n_ob[0], 0);
        check("post-reset ch_state", int'(ch_state[1:0]), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
